regfile_write_scheduler: RTL and testbench
==========================================

REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 SHALL have parameter NREGS, default 16, number of registers tracked; index width is 4 bits.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising clock edge.
REQ-004 SHALL have ports alu_req / alu_index / alu_data  input  1/4/32  ALU result writeback request; requester holds it stable until granted.
REQ-005 SHALL have port alu_ready  output  1  combinational grant to the ALU requester in the current cycle.
REQ-006 SHALL have ports imm_req / imm_index / imm_data / imm_type  input  1/4/16/2  immediate-write request (IT_BOTTOM/IT_TOP/IT_UNSIGNED/IT_SIGNED); requester holds it until granted.
REQ-007 SHALL have port imm_ready  output  1  combinational grant to the immediate requester.
REQ-008 SHALL have ports load_issue / load_issue_index  input  1/4  marks a register as awaiting load data.
REQ-009 SHALL have ports load_req / load_index / load_data  input  1/4/32  load-return writeback; cannot be stalled.
REQ-010 SHALL have ports write / write_index / write_data  output  1/4/32  register-file full-word write port, registered.
REQ-011 SHALL have ports write_immediate / write_immediate_data / write_immediate_type  output  1/16/2  register-file immediate port, registered.
REQ-012 SHALL have port busy  output  16  scoreboard; bit n set means register n has a load outstanding.
REQ-013 SHALL have port sb_error  output  1  sticky scoreboard protocol-violation flag.

Function
REQ-014 SHALL grant at most one requester per cycle; write and write_immediate SHALL never both be 1.
REQ-015 SHALL give load_req absolute priority; alu_ready and imm_ready SHALL both be 0 in any cycle with load_req=1.
REQ-016 SHALL arbitrate alu_req vs imm_req round-robin via a 1-bit last-grant register; when both are eligible, the one not granted last wins.
REQ-017 SHALL treat a lone eligible requester as granted regardless of the last-grant pointer, and SHALL update the pointer only on a grant.
REQ-018 SHALL make an ALU or immediate request ineligible while busy[index]=1 (WAW protection); it waits with ready=0.
REQ-019 SHALL drive, on the edge after a grant (latency 1), the corresponding write or write_immediate=1 with the granted index and data; with no grant, both strobes SHALL be 0 the next cycle and data outputs SHALL hold their values.
REQ-020 SHALL, on load_issue, set busy[load_issue_index] at the next edge.
REQ-021 SHALL, on load_req, clear busy[load_index] at the next edge, in the same edge as write=1.
REQ-022 SHALL, on simultaneous load_req and load_issue to the same index, leave the bit set; to different indices, apply both.
REQ-023 SHALL set sb_error on load_issue to an already-busy register that is not being cleared that cycle, or on load_req to a non-busy register; the load write SHALL still occur.
REQ-024 SHALL keep sb_error set until reset.
REQ-025 SHALL allow a request for register n to be granted in the cycle after busy[n] clears, not in the same cycle as load_req to n.

Reset
REQ-026 SHALL, with reset=0 at a rising edge, clear busy to 16'h0000, sb_error, write, write_immediate, write_index, write_data, write_immediate_data and write_immediate_type (=IT_BOTTOM) to 0, and set the last-grant pointer so ALU wins the first tie.
REQ-027 SHALL hold alu_ready and imm_ready at 0 while reset=0.
REQ-028 SHALL drop a grant made in the cycle reset is asserted; no write strobe follows it.

Verification
REQ-029 ALU write: alu_req=1, index 2, data 32'hdeadbeef -> alu_ready=1 same cycle; next cycle write=1, write_index=2, write_data=32'hdeadbeef.
REQ-030 Round-robin: alu_req and imm_req (index 3, 16'hbeef, IT_TOP) held together for 2 cycles after reset -> ALU granted first, immediate second; write_immediate=1 with 16'hbeef, IT_TOP.
REQ-031 Load priority: load_req (r5, 32'h12345678) together with alu_req (r1) -> alu_ready=0; next cycle write_index=5, data 32'h12345678; ALU granted the following cycle.
REQ-032 WAW stall: load_issue r4, then alu_req r4 -> busy=16'h0010, alu_ready=0 until load_req r4; ALU write to r4 occurs after the load write.
REQ-033 Protocol error: load_req r7 with busy[7]=0 -> write to r7 occurs, sb_error=1 and stays 1 until reset=0.
REQ-034 Reset mid-operation: busy=16'h0014, pending alu_req, reset=0 for one edge -> busy=0, sb_error=0, no write strobe, alu_ready=0 during reset.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Arbitrates ALU, immediate and load-return writebacks onto the register file ports, tracking outstanding loads.
// Latency: grant is combinational; the write / write_immediate strobe follows one clock after the grant.
// Backpressure: loads can never stall; ALU/immediate requesters wait with ready=0 while a load returns or their target is busy.
module regfile_write_scheduler #(
    parameter int NREGS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alu_req,
    input  logic [3:0]       alu_index,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    input  logic             imm_req,
    input  logic [3:0]       imm_index,
    input  logic [15:0]      imm_data,
    input  logic [1:0]       imm_type,
    output logic             imm_ready,
    input  logic             load_issue,
    input  logic [3:0]       load_issue_index,
    input  logic             load_req,
    input  logic [3:0]       load_index,
    input  logic [31:0]      load_data,
    output logic             write,
    output logic [3:0]       write_index,
    output logic [31:0]      write_data,
    output logic             write_immediate,
    output logic [15:0]      write_immediate_data,
    output logic [1:0]       write_immediate_type,
    output logic [NREGS-1:0] busy,
    output logic             sb_error
);

    typedef enum logic [1:0] {
        IT_BOTTOM   = 2'd0,
        IT_TOP      = 2'd1,
        IT_UNSIGNED = 2'd2,
        IT_SIGNED   = 2'd3
    } imm_type_t;

    // 1 = ALU was granted most recently, so the immediate side wins the next tie.
    logic             last_alu;
    logic             alu_elig;
    logic             imm_elig;
    logic             arb_open;
    logic [NREGS-1:0] busy_nxt;
    logic             proto_err;

    // Grant: load return blocks everyone, busy targets are ineligible, ties go to the side not granted last.
    always_comb begin
        alu_elig  = alu_req && !busy[alu_index];
        imm_elig  = imm_req && !busy[imm_index];
        arb_open  = reset && !load_req;
        alu_ready = arb_open && alu_elig && (!imm_elig || !last_alu);
        imm_ready = arb_open && imm_elig && (!alu_elig || last_alu);
    end

    // Scoreboard next state: clear on load return first so a same-index issue leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (load_req)
            busy_nxt[load_index] = 1'b0;
        if (load_issue)
            busy_nxt[load_issue_index] = 1'b1;
        proto_err = (load_issue && busy[load_issue_index] &&
                     !(load_req && (load_index == load_issue_index))) ||
                    (load_req && !busy[load_index]);
    end

    // Scoreboard and sticky protocol-error flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy     <= '0;
            sb_error <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (proto_err)
                sb_error <= 1'b1;
        end
    end

    // Register-file write ports: strobes pulse for one cycle, data holds when nothing is granted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            write                <= 1'b0;
            write_index          <= '0;
            write_data           <= '0;
            write_immediate      <= 1'b0;
            write_immediate_data <= '0;
            write_immediate_type <= IT_BOTTOM;
        end else begin
            write           <= load_req || alu_ready;
            write_immediate <= imm_ready;
            if (load_req) begin
                write_index <= load_index;
                write_data  <= load_data;
            end else if (alu_ready) begin
                write_index <= alu_index;
                write_data  <= alu_data;
            end
            if (imm_ready) begin
                write_immediate_data <= imm_data;
                write_immediate_type <= imm_type;
            end
        end
    end

    // Round-robin pointer moves only when someone is actually granted.
    always_ff @(posedge clock) begin
        if (!reset)
            last_alu <= 1'b0;
        else if (alu_ready)
            last_alu <= 1'b1;
        else if (imm_ready)
            last_alu <= 1'b0;
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
module tb_regfile_write_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_req;
    logic [3:0]  alu_index;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        imm_req;
    logic [3:0]  imm_index;
    logic [15:0] imm_data;
    logic [1:0]  imm_type;
    logic        imm_ready;
    logic        load_issue;
    logic [3:0]  load_issue_index;
    logic        load_req;
    logic [3:0]  load_index;
    logic [31:0] load_data;
    logic        write;
    logic [3:0]  write_index;
    logic [31:0] write_data;
    logic        write_immediate;
    logic [15:0] write_immediate_data;
    logic [1:0]  write_immediate_type;
    logic [15:0] busy;
    logic        sb_error;

    regfile_write_scheduler #(.NREGS(16)) dut (
        .clock(clock), .reset(reset),
        .alu_req(alu_req), .alu_index(alu_index), .alu_data(alu_data), .alu_ready(alu_ready),
        .imm_req(imm_req), .imm_index(imm_index), .imm_data(imm_data), .imm_type(imm_type),
        .imm_ready(imm_ready),
        .load_issue(load_issue), .load_issue_index(load_issue_index),
        .load_req(load_req), .load_index(load_index), .load_data(load_data),
        .write(write), .write_index(write_index), .write_data(write_data),
        .write_immediate(write_immediate), .write_immediate_data(write_immediate_data),
        .write_immediate_type(write_immediate_type),
        .busy(busy), .sb_error(sb_error)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the register file should have been told, kept as plain values.
    bit          m_busy [16];
    bit          m_alu_first;
    bit          m_err;
    bit          m_wr;
    logic [3:0]  m_wr_idx;
    logic [31:0] m_wr_dat;
    bit          m_wi;
    logic [15:0] m_wi_dat;
    logic [1:0]  m_wi_type;
    bit          e_ga;
    bit          e_gi;
    logic        obs_a;
    logic        obs_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] busy_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Which requester should win this cycle, from the arbitration rules.
    task automatic predict();
        bit a_ok, i_ok;
        a_ok = alu_req && !m_busy[alu_index];
        i_ok = imm_req && !m_busy[imm_index];
        e_ga = 0;
        e_gi = 0;
        if (reset && !load_req) begin
            if (a_ok && i_ok) begin
                e_ga = m_alu_first;
                e_gi = !m_alu_first;
            end else begin
                e_ga = a_ok;
                e_gi = i_ok;
            end
        end
    endtask

    task automatic model_edge();
        bit err_now;
        if (!reset) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_err = 0; m_wr = 0; m_wi = 0;
            m_wr_idx = 0; m_wr_dat = 0; m_wi_dat = 0; m_wi_type = 0;
            m_alu_first = 1;
            return;
        end
        m_wr = load_req || e_ga;
        if (load_req) begin
            m_wr_idx = load_index; m_wr_dat = load_data;
        end else if (e_ga) begin
            m_wr_idx = alu_index; m_wr_dat = alu_data;
        end
        m_wi = e_gi;
        if (e_gi) begin
            m_wi_dat = imm_data; m_wi_type = imm_type;
        end
        err_now = 0;
        if (load_req && !m_busy[load_index]) err_now = 1;
        if (load_issue && m_busy[load_issue_index] && !(load_req && load_index == load_issue_index))
            err_now = 1;
        if (err_now) m_err = 1;
        if (load_req) m_busy[load_index] = 0;
        if (load_issue) m_busy[load_issue_index] = 1;
        if (e_ga) m_alu_first = 0;
        if (e_gi) m_alu_first = 1;
    endtask

    // One clock: check grants at the falling edge, advance the model, check registered outputs just after the rising edge.
    task automatic step();
        @(negedge clock);
        predict();
        obs_a = alu_ready;
        obs_i = imm_ready;
        chk("alu_ready", alu_ready, e_ga);
        chk("imm_ready", imm_ready, e_gi);
        @(posedge clock);
        model_edge();
        #1;
        chk("write", write, m_wr);
        chk("write_index", write_index, m_wr_idx);
        chk("write_data", write_data, m_wr_dat);
        chk("write_immediate", write_immediate, m_wi);
        chk("write_imm_data", write_immediate_data, m_wi_dat);
        chk("write_imm_type", write_immediate_type, m_wi_type);
        chk("busy", busy, busy_vec());
        chk("sb_error", sb_error, m_err);
    endtask

    task automatic idle();
        alu_req = 0; imm_req = 0; load_issue = 0; load_req = 0;
    endtask

    task automatic next_random();
        logic [31:0] r;
        logic [3:0]  start;
        int          found;
        r = $urandom;
        reset = (r[5:0] != 0);
        if (!alu_req || e_ga) begin
            r = $urandom;
            alu_req = r[0]; alu_index = r[7:4];
            alu_data = $urandom;
        end
        if (!imm_req || e_gi) begin
            r = $urandom;
            imm_req = r[0]; imm_index = r[7:4]; imm_data = r[31:16]; imm_type = r[9:8];
        end
        r = $urandom;
        load_issue_index = r[3:0];
        load_issue = (r[5:4] == 0) && (!m_busy[r[3:0]] || r[9:6] == 0);
        r = $urandom;
        start = r[3:0];
        found = -1;
        for (int k = 0; k < 16; k++) begin
            if (found < 0 && m_busy[(int'(start) + k) % 16]) found = (int'(start) + k) % 16;
        end
        load_data = $urandom;
        load_index = start;
        load_req = 0;
        if (found >= 0 && r[5:4] == 0) begin
            load_req = 1; load_index = 4'(found);
        end else if (r[15:8] == 0) begin
            load_req = 1;
        end
    endtask

    initial begin
        reset = 0; idle();
        alu_index = 0; alu_data = 0; imm_index = 0; imm_data = 0; imm_type = 0;
        load_issue_index = 0; load_index = 0; load_data = 0;
        step();
        chk("rst_busy", busy, 32'h0);
        chk("rst_write", write, 32'h0);
        step();
        reset = 1;
        step();

        // Tie straight after reset: ALU first, immediate second.
        alu_req = 1; alu_index = 1; alu_data = 32'h11111111;
        imm_req = 1; imm_index = 3; imm_data = 16'hbeef; imm_type = 2'd1;
        step();
        chk("rr_first_alu", obs_a, 32'h1);
        chk("rr_first_imm", obs_i, 32'h0);
        step();
        chk("rr_second_imm", obs_i, 32'h1);
        chk("rr_wi", write_immediate, 32'h1);
        chk("rr_wi_data", write_immediate_data, 32'hbeef);
        chk("rr_wi_type", write_immediate_type, 32'h1);
        idle();

        // Plain ALU write.
        alu_req = 1; alu_index = 2; alu_data = 32'hdeadbeef;
        step();
        chk("alu_grant", obs_a, 32'h1);
        chk("alu_wr_idx", write_index, 32'h2);
        chk("alu_wr_data", write_data, 32'hdeadbeef);
        idle();

        // Load return beats a waiting ALU request.
        load_issue = 1; load_issue_index = 5;
        step();
        idle();
        load_req = 1; load_index = 5; load_data = 32'h12345678;
        alu_req = 1; alu_index = 1; alu_data = 32'ha5a5a5a5;
        step();
        chk("ld_prio_rdy", obs_a, 32'h0);
        chk("ld_prio_idx", write_index, 32'h5);
        chk("ld_prio_data", write_data, 32'h12345678);
        load_req = 0;
        step();
        chk("ld_prio_after", obs_a, 32'h1);
        chk("ld_prio_alu_idx", write_index, 32'h1);
        idle();

        // WAW stall on a busy register.
        load_issue = 1; load_issue_index = 4;
        step();
        chk("waw_busy", busy, 32'h0010);
        idle();
        alu_req = 1; alu_index = 4; alu_data = 32'hcafef00d;
        step();
        chk("waw_stall1", obs_a, 32'h0);
        step();
        chk("waw_stall2", obs_a, 32'h0);
        load_req = 1; load_index = 4; load_data = 32'h44444444;
        step();
        chk("waw_ld_idx", write_index, 32'h4);
        chk("waw_ld_busy", busy, 32'h0);
        load_req = 0;
        step();
        chk("waw_release", obs_a, 32'h1);
        chk("waw_alu_data", write_data, 32'hcafef00d);
        chk("no_err_yet", sb_error, 32'h0);
        idle();

        // Load return to a register nobody issued to.
        load_req = 1; load_index = 7; load_data = 32'h77777777;
        step();
        chk("err_wr_idx", write_index, 32'h7);
        chk("err_flag", sb_error, 32'h1);
        idle();
        step(); step();
        chk("err_sticky", sb_error, 32'h1);

        // Reset in the middle of activity.
        load_issue = 1; load_issue_index = 2;
        step();
        load_issue_index = 4;
        step();
        chk("mid_busy", busy, 32'h0014);
        idle();
        alu_req = 1; alu_index = 9; alu_data = 32'h99999999;
        reset = 0;
        step();
        chk("mid_rst_rdy", obs_a, 32'h0);
        chk("mid_rst_busy", busy, 32'h0);
        chk("mid_rst_err", sb_error, 32'h0);
        chk("mid_rst_wr", write, 32'h0);
        reset = 1;
        step();
        idle();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            next_random();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
